// File: rtl/canny_mac_pkg.sv
// canny_mac_pkg: shared types and helpers for the canny multiply-accumulate pipeline.
//   - Default operand, accumulator and output widths.
//   - ctrl_t: {valid, first, last} bits travelling alongside each product.
//   - sat_shift(): arithmetic right shift of the accumulator followed by a signed clamp.
// Optional feature macro: CANNY_MAC_ROUND_EN (round-half-up instead of floor in sat_shift).
package canny_mac_pkg;

  localparam int unsigned DefAW   = 11;
  localparam int unsigned DefBW   = 11;
  localparam int unsigned DefAccW = 32;
  localparam int unsigned DefOutW = 16;

  // Working width of sat_shift; accumulator and output widths must stay below this.
  localparam int unsigned SatW = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } ctrl_t;

  typedef struct packed {
    logic            sat;
    logic [SatW-1:0] value;
  } sat_res_t;

  // acc is the sign-extended accumulator. One extra bit keeps the rounding add exact.
  function automatic sat_res_t sat_shift(input logic signed [SatW-1:0] acc,
                                         input int unsigned           shift,
                                         input int unsigned           out_w);
    sat_res_t           res;
    logic signed [SatW:0] s;
    logic signed [SatW:0] hi;
    logic signed [SatW:0] lo;
    s = {acc[SatW-1], acc};
`ifdef CANNY_MAC_ROUND_EN
    if (shift > 0) begin
      s = s + ((SatW+1)'(1) <<< (shift - 1));
    end
`endif
    s  = s >>> shift;
    hi = ((SatW+1)'(1) <<< (out_w - 1)) - (SatW+1)'(1);
    lo = -((SatW+1)'(1) <<< (out_w - 1));
    if (s > hi) begin
      res.sat   = 1'b1;
      res.value = hi[SatW-1:0];
    end else if (s < lo) begin
      res.sat   = 1'b1;
      res.value = lo[SatW-1:0];
    end else begin
      res.sat   = 1'b0;
      res.value = s[SatW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/canny_mac_sat.sv
// canny_mac_sat: combinational shift / optional round / clamp from accumulator to output.
// Ports:
//   i_acc   in  ACC_W  signed accumulator value
//   o_dout  out OUT_W  shifted, clamped result
//   o_sat   out 1      clamp occurred
// Optional feature macro: CANNY_MAC_ROUND_EN (applied inside sat_shift).
module canny_mac_sat
  import canny_mac_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned SHIFT = 0
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [OUT_W-1:0] o_dout,
  output logic             o_sat
);

  logic [SatW-1:0] w_acc_ext;
  sat_res_t        w_res;
  logic            w_unused_hi;

  assign w_acc_ext = SatW'($signed(i_acc));
  assign w_res     = sat_shift(w_acc_ext, SHIFT, OUT_W);
  assign o_dout    = w_res.value[OUT_W-1:0];
  assign o_sat     = w_res.sat;

  // Upper bits are only the sign extension of the clamped value.
  assign w_unused_hi = ^w_res.value[SatW-1:OUT_W];

endmodule

// File: rtl/canny_mac_pipe.sv
// canny_mac_pipe: fully pipelined signed multiply-accumulate with grouped accumulation.
// Latency is STAGES enabled cycles from acceptance to out_valid.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-low reset
//   ce         in  1      clock enable; all registers hold when 0
//   in_valid   in  1      accept din0*din1 this cycle
//   in_first   in  1      product starts a new group (acc loads)
//   in_last    in  1      product ends its group (result emitted)
//   din0       in  A_W    signed operand
//   din1       in  B_W    signed operand
//   out_valid  out 1      dout holds a new group result
//   dout       out OUT_W  shifted, saturated accumulator
//   out_sat    out 1      dout was clamped
// Optional feature macro: CANNY_MAC_ROUND_EN (round-half-up on the output shift).
module canny_mac_pipe
  import canny_mac_pkg::*;
#(
  parameter int unsigned A_W    = DefAW,
  parameter int unsigned B_W    = DefBW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned STAGES = 4,
  parameter int unsigned SHIFT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             out_sat
);

  localparam int unsigned PW = A_W + B_W;

  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  ctrl_t            r_c1;
  logic [PW-1:0]    r_p;
  ctrl_t            r_c2;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_fin_p;
  ctrl_t            w_fin_c;
  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_acc_next;
  logic [OUT_W-1:0] w_sat_dout;
  logic             w_sat;
  logic [ACC_W-1:0] r_acc;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_dout;
  logic             r_out_sat;

  // Stage 1: operand and control capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c1 <= '0;
    end else if (ce) begin
      r_a        <= din0;
      r_b        <= din1;
      r_c1.valid <= in_valid;
      r_c1.first <= in_first;
      r_c1.last  <= in_last;
    end
  end

  // Sign-extended operands at full width give the exact signed product modulo 2^PW.
  assign w_prod = {{B_W{r_a[A_W-1]}}, r_a} * {{A_W{r_b[B_W-1]}}, r_b};

  // Stage 2: full-precision product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p  <= '0;
      r_c2 <= '0;
    end else if (ce) begin
      r_p  <= w_prod;
      r_c2 <= r_c1;
    end
  end

  // Stages 3..STAGES-1: pure delay.
  if (STAGES > 3) begin : g_dly
    logic [PW-1:0] r_dp [STAGES-3];
    ctrl_t         r_dc [STAGES-3];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(STAGES - 3); i++) begin
          r_dp[i] <= '0;
          r_dc[i] <= '0;
        end
      end else if (ce) begin
        r_dp[0] <= r_p;
        r_dc[0] <= r_c2;
        for (int i = 1; i < int'(STAGES - 3); i++) begin
          r_dp[i] <= r_dp[i-1];
          r_dc[i] <= r_dc[i-1];
        end
      end
    end

    assign w_fin_p = r_dp[STAGES-4];
    assign w_fin_c = r_dc[STAGES-4];
  end else begin : g_nodly
    assign w_fin_p = r_p;
    assign w_fin_c = r_c2;
  end

  // Final stage: accumulate (wrapping) and register the group result on last.
  assign w_p_ext    = ACC_W'($signed(w_fin_p));
  assign w_acc_next = w_fin_c.first ? w_p_ext : r_acc + w_p_ext;

  canny_mac_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .i_acc  (w_acc_next),
    .o_dout (w_sat_dout),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_out_sat   <= 1'b0;
    end else if (ce) begin
      r_out_valid <= 1'b0;
      if (w_fin_c.valid) begin
        r_acc <= w_acc_next;
        if (w_fin_c.last) begin
          r_out_valid <= 1'b1;
          r_dout      <= w_sat_dout;
          r_out_sat   <= w_sat;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_canny_mac_pipe.sv
// Directed bench for canny_mac_pipe. Three instances share one stimulus stream:
//   u_d: defaults (OUT_W=16, SHIFT=0)
//   u_w: ACC_W=32, OUT_W=32
//   u_s: SHIFT=4 (expected values depend on CANNY_MAC_ROUND_EN)
module tb_canny_mac_pipe;

`ifdef CANNY_MAC_ROUND_EN
  localparam int S5000 = -312;
`else
  localparam int S5000 = -313;
`endif

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        iv;
  logic        ifst;
  logic        ilst;
  logic [10:0] a;
  logic [10:0] b;

  logic        ov_d, sat_d, ov_w, sat_w, ov_s, sat_s;
  logic [15:0] dout_d;
  logic [31:0] dout_w;
  logic [15:0] dout_s;

  int n_checks = 0;
  int n_errors = 0;

  canny_mac_pipe u_d (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(iv), .in_first(ifst), .in_last(ilst),
    .din0(a), .din1(b), .out_valid(ov_d), .dout(dout_d), .out_sat(sat_d)
  );

  canny_mac_pipe #(.ACC_W(32), .OUT_W(32)) u_w (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(iv), .in_first(ifst), .in_last(ilst),
    .din0(a), .din1(b), .out_valid(ov_w), .dout(dout_w), .out_sat(sat_w)
  );

  canny_mac_pipe #(.SHIFT(4)) u_s (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(iv), .in_first(ifst), .in_last(ilst),
    .din0(a), .din1(b), .out_valid(ov_s), .dout(dout_s), .out_sat(sat_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic ev,
                      input int ed, input logic eds,
                      input int ew, input logic ews,
                      input int es, input logic ess);
    chk({tag, ".d.valid"}, {63'd0, ov_d}, {63'd0, ev});
    chk({tag, ".d.dout"}, $signed(dout_d), ed);
    chk({tag, ".d.sat"}, {63'd0, sat_d}, {63'd0, eds});
    chk({tag, ".w.valid"}, {63'd0, ov_w}, {63'd0, ev});
    chk({tag, ".w.dout"}, $signed(dout_w), ew);
    chk({tag, ".w.sat"}, {63'd0, sat_w}, {63'd0, ews});
    chk({tag, ".s.valid"}, {63'd0, ov_s}, {63'd0, ev});
    chk({tag, ".s.dout"}, $signed(dout_s), es);
    chk({tag, ".s.sat"}, {63'd0, sat_s}, {63'd0, ess});
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input int av, input int bv);
    iv   = v;
    ifst = f;
    ilst = l;
    a    = 11'(av);
    b    = 11'(bv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    ce    = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk3("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Single product 100 x -50, first=last=1: result after 4 enabled edges.
    drive(1, 1, 1, 100, -50);
    tick();
    drive(0, 0, 0, 0, 0);
    chk3("t1.e1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk3("t1.e2", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk3("t1.e3", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk3("t1.out", 1, -5000, 0, -5000, 0, S5000, 0);
    tick();
    chk3("t1.hold", 0, -5000, 0, -5000, 0, S5000, 0);

    // Three-product group of 1023*1023; acc = 3139587, one pulse only.
    drive(1, 1, 0, 1023, 1023);
    tick();
    drive(1, 0, 0, 1023, 1023);
    tick();
    drive(1, 0, 1, 1023, 1023);
    tick();
    drive(0, 0, 0, 0, 0);
    chk3("t2.k0", 0, -5000, 0, -5000, 0, S5000, 0);
    tick();
    chk3("t2.k1", 0, -5000, 0, -5000, 0, S5000, 0);
    tick();
    chk3("t2.k2", 0, -5000, 0, -5000, 0, S5000, 0);
    tick();
    chk3("t2.out", 1, 32767, 1, 3139587, 0, 32767, 1);
    tick();
    chk3("t2.hold", 0, 32767, 1, 3139587, 0, 32767, 1);

    // -1024 x -1024 single, then back-to-back group 5*3 + (-2)*7 = 1.
    drive(1, 1, 1, -1024, -1024);
    tick();
    drive(1, 1, 0, 5, 3);
    tick();
    drive(1, 0, 1, -2, 7);
    tick();
    drive(0, 0, 0, 0, 0);
    chk3("t3.k2", 0, 32767, 1, 3139587, 0, 32767, 1);
    tick();
    chk3("t3.single", 1, 32767, 1, 1048576, 0, 32767, 1);
    tick();
    chk3("t3.mid", 0, 32767, 1, 1048576, 0, 32767, 1);
    tick();
    chk3("t3.group", 1, 1, 0, 1, 0, 0, 0);
    tick();
    chk3("t3.hold", 0, 1, 0, 1, 0, 0, 0);

    // ce low for 3 edges while the product sits in stage 2: out_valid 7 edges after accept.
    drive(1, 1, 1, 100, -50);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3("t4.stall", 0, 1, 0, 1, 0, 0, 0);
    end
    ce = 1'b1;
    tick();
    chk3("t4.e6", 0, 1, 0, 1, 0, 0, 0);
    tick();
    chk3("t4.out", 1, -5000, 0, -5000, 0, S5000, 0);
    ce = 1'b0;
    tick();
    chk3("t4.ce0hold", 1, -5000, 0, -5000, 0, S5000, 0);
    ce = 1'b1;
    tick();
    chk3("t4.drop", 0, -5000, 0, -5000, 0, S5000, 0);

    // Reset mid-group discards in-flight beats and the accumulator.
    drive(1, 1, 0, 7, 9);
    tick();
    drive(1, 0, 1, 7, 9);
    tick();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk3("t6.async", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk3("t6.nopulse", 0, 0, 0, 0, 0, 0, 0);
    end

    // Continuation (last without first) adds to the cleared acc: 0 + 2*3.
    drive(1, 0, 1, 2, 3);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk3("t6.cont", 1, 6, 0, 6, 0, 0, 0);

    // Single 4 x -3 = -12; SHIFT=4 gives -1 in both builds.
    drive(1, 1, 1, 4, -3);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk3("t6.single", 1, -12, 0, -12, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/canny_mac_pipe.md
Name: canny_mac_pipe

Overview:
- Parametrised, fully pipelined signed multiply-accumulate unit for the canny datapath, used for gradient magnitude (Gx²+Gy²) and kernel dot products.
- Generalises the fixed 11x11 four-stage multiplier with configurable operand widths and pipeline depth.
- Adds a valid pipeline, grouped accumulation (first/last markers), and an arithmetic shift with saturation on the output.
- Sits between the Sobel stage and non-maximum suppression; one product is accepted per enabled cycle.

Parameters:
- A_W, 11, width of signed operand din0
- B_W, 11, width of signed operand din1
- ACC_W, 32, accumulator width; must be at least A_W+B_W
- OUT_W, 16, width of signed output dout
- STAGES, 4, input-to-output latency in enabled cycles; legal range 3..8
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation; legal range 0..ACC_W-1

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- reset  in  1  asynchronous reset, active-low; clears all state
- ce  in  1  clock enable; when 0, every register in the block holds its value
- in_valid  in  1  din0/din1 carry a product to accept this cycle
- in_first  in  1  product starts a new accumulation group
- in_last  in  1  product ends its group; its result is emitted
- din0  in  A_W  signed operand
- din1  in  B_W  signed operand
- out_valid  out  1  dout holds a new group result
- dout  out  OUT_W  shifted, saturated accumulator result
- out_sat  out  1  dout was clamped; valid only when out_valid=1

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers, valid/ctrl bits, the accumulator, out_valid, dout and out_sat clear to 0.
- A product is accepted when ce=1 and in_valid=1. No backpressure: the block accepts one product per enabled cycle.
- Stage 1 registers din0, din1, in_valid, in_first and in_last.
- Stage 2 registers the full-precision signed product, width A_W+B_W.
- Stages 3..STAGES-1 are pure delay registers for the product and ctrl bits. With STAGES=3 there are none.
- Stage STAGES is the final stage. When the arriving valid bit is 1:
  - the accumulator acc loads sext(product) if first=1, otherwise acc becomes acc+sext(product);
  - the addition wraps modulo 2^ACC_W;
  - if last=1, out_valid is registered as 1 and dout/out_sat are registered from the new acc value.
- When the arriving valid bit is 0, or last=0: out_valid is registered as 0 and dout/out_sat hold their previous values.
- Latency: exactly STAGES enabled cycles from acceptance to out_valid. Cycles with ce=0 do not count.
- Output arithmetic: s = acc >>> SHIFT (floor). dout = clamp(s) to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 if and only if a clamp occurred.
- Bubbles (in_valid=0) inside a group leave acc unchanged.
- last=1 without a preceding first: the product adds to whatever acc currently holds. This is legal and is used for continuation.
- first=1 and last=1 on the same product is a single-product group; its result is the product itself.
- Back-to-back groups need no gap cycle: a first immediately after a last loads fresh.
- ce=0 while out_valid=1: out_valid stays 1. Consumers sample it only on ce=1 cycles.
- Reset during an operation discards all in-flight products and the partial accumulator. No output pulse is produced for the discarded group.

Optional Feature:
- Macro: CANNY_MAC_ROUND_EN.
- Defined: s = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round-half-up, with the addition done at ACC_W+1 bits so it cannot overflow. Rounding applies only when SHIFT>0.
- Not defined: truncation (floor) as described above.
- Latency is the same in both builds.

Decomposition:
- Package canny_mac_pkg holds:
  - default width constants (A_W, B_W, ACC_W, OUT_W);
  - a ctrl struct typedef {valid, first, last} carried through the delay stages;
  - a pure function sat_shift(acc, shift, out_w) returning {sat, value}.
- One natural sub-module, canny_mac_sat: combinational shift/round/clamp from acc to {dout, out_sat}, instantiated ahead of the final output register.

Test Plan:
- Defaults, single product 100 × -50 with first=last=1 → out_valid exactly 4 cycles later, dout=-5000, out_sat=0.
- Three-product group 1023×1023 (first, -, last) → acc=3139587, dout=32767, out_sat=1, with one out_valid pulse only.
- -1024 × -1024 single, OUT_W=32, ACC_W=32 → dout=1048576. Then 5×3 (first) followed by -2×7 (last) → dout=1.
- ce held low for 3 cycles while a product is in stage 2 → out_valid appears 7 clock cycles after acceptance, dout=-5000 unchanged.
- SHIFT=4, single -5000 → truncation build gives dout=-313; CANNY_MAC_ROUND_EN build gives -312.
- Two-beat group in flight, reset pulsed low for 1 cycle → out_valid=0, dout=0, acc=0. A following single 2×3 → dout=6.
